// File: rtl/apb_uart_host_pkg.sv
// apb_uart_host_pkg
// Shared constants and types for the APB UART host: 16550 register indices,
// LSR/LCR bit positions, sequencer and single-transfer state encodings, and
// a helper that turns a register index into a word-spaced APB address.
package apb_uart_host_pkg;

  // 16550 register indices; the UART decodes PADDR[4:2].
  localparam logic [2:0] REG_RBR_THR = 3'd0;  // also DLL when DLAB=1
  localparam logic [2:0] REG_IER     = 3'd1;  // also DLM when DLAB=1
  localparam logic [2:0] REG_FCR     = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_MCR     = 3'd4;
  localparam logic [2:0] REG_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;
  localparam int DLAB_BIT = 7;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL,
    ST_RD_RBR,
    ST_WR_THR
  } host_state_e;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_SETUP,
    XF_ACCESS
  } xfer_state_e;

  // Index into the six-write init sequence.
  typedef logic [2:0] init_step_t;
  localparam init_step_t LAST_INIT_STEP = 3'd5;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_uart_host_xfer.sv
// apb_single_xfer
// Performs one APB transfer per request: SETUP for one cycle, then ACCESS
// held until pready. Address, write data and direction are latched when the
// request is accepted so they stay stable for the whole transfer.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req                start a transfer (accepted only while idle)
//   addr/wdata/write   transfer parameters, sampled on acceptance
//   done               1 in the completion cycle (ACCESS & pready)
//   rdata              prdata[7:0] (meaningful with done)
//   slverr             pslverr qualified by done
//   state_dbg          current transfer state
//   paddr..pwdata      APB requester outputs
//   prdata/pready/pslverr APB completer responses
module apb_single_xfer
  import apb_uart_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        slverr,
  output xfer_state_e state_dbg,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  xfer_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= XF_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      XF_IDLE:   if (req) state_d = XF_SETUP;
      XF_SETUP:  state_d = XF_ACCESS;
      XF_ACCESS: if (pready) state_d = XF_IDLE;
      default:   state_d = XF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (state_q == XF_IDLE && req) begin
      paddr  <= addr;
      pwdata <= wdata;
      pwrite <= write;
    end
  end

  // psel/penable come straight from the state register, so a reset that
  // lands mid-transfer drops them immediately.
  assign psel      = (state_q != XF_IDLE);
  assign penable   = (state_q == XF_ACCESS);
  assign done      = penable & pready;
  assign slverr    = done & pslverr;
  assign rdata     = prdata[7:0];
  assign state_dbg = state_q;

  // Only the low byte carries UART data.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata[31:8];

endmodule

// File: rtl/apb_uart_host.sv
// apb_uart_host
// APB requester for a 16550-style UART. After reset it programs LCR/DLL/DLM/
// LCR/FCR/IER, then polls LSR and moves bytes between the tx/rx byte streams
// and THR/RBR, one APB transfer at a time.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   paddr_o..pwdata_o         APB requester outputs
//   prdata_i, pready_i, pslverr_i  APB completer responses
//   tx_data_i/tx_valid_i/tx_ready_o  byte stream into the UART
//   rx_data_o/rx_valid_o/rx_ready_i  byte stream out of the UART
//   init_done_o               init sequence finished
//   err_o                     sticky PSLVERR flag
// Stream handshake: a byte moves on a cycle where valid & ready are both 1;
// valid never depends on ready, and data is held stable while valid & !ready.
module apb_uart_host
  import apb_uart_host_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter logic [15:0] Divisor  = 16'd27,
  parameter logic [7:0]  LcrValue = 8'h03,
  parameter logic [7:0]  FcrValue = 8'h07,
  parameter int          PollGap  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        init_done_o,
  output logic        err_o
);

  localparam int GW = (PollGap < 1) ? 1 : $clog2(PollGap + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(PollGap);

  host_state_e state_q, state_d;
  init_step_t  init_step_q;
  logic [GW-1:0] gap_q;
  logic        rr_rx_q;     // 1: rx wins the next contested grant
  logic        tx_full_q, rx_full_q;
  logic [7:0]  tx_byte_q, rx_byte_q;
  logic        init_done_q, err_q;

  logic        xreq, xwrite, xdone, xslverr;
  logic [31:0] xaddr, xwdata;
  logic [7:0]  xrdata;
  xfer_state_e xfer_state;

  logic [7:0]  lsr;
  logic        rx_elig, tx_elig, contested;

  apb_single_xfer u_xfer (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (xreq),
    .addr      (xaddr),
    .wdata     (xwdata),
    .write     (xwrite),
    .done      (xdone),
    .rdata     (xrdata),
    .slverr    (xslverr),
    .state_dbg (xfer_state),
    .paddr     (paddr_o),
    .psel      (psel_o),
    .penable   (penable_o),
    .pwrite    (pwrite_o),
    .pwdata    (pwdata_o),
    .prdata    (prdata_i),
    .pready    (pready_i),
    .pslverr   (pslverr_i)
  );

  // An errored LSR read is treated as "nothing ready".
  assign lsr       = xslverr ? 8'h00 : xrdata;
  assign rx_elig   = lsr[LSR_DR] & ~rx_full_q;
  assign tx_elig   = lsr[LSR_THRE] & tx_full_q;
  assign contested = rx_elig & tx_elig;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Each bus-using state keeps req high; the transfer engine only accepts it
  // while idle, and the state moves on at the completion edge, so exactly one
  // transfer is issued per state visit (or per init step).
  always_comb begin
    state_d = state_q;
    xreq    = 1'b0;
    xwrite  = 1'b0;
    xaddr   = reg_addr(BaseAddr, REG_LSR);
    xwdata  = '0;
    case (state_q)
      ST_INIT: begin
        xreq   = 1'b1;
        xwrite = 1'b1;
        case (init_step_q)
          3'd0: begin
            xaddr  = reg_addr(BaseAddr, REG_LCR);
            xwdata = {24'd0, LcrValue | 8'(1 << DLAB_BIT)};
          end
          3'd1: begin
            xaddr  = reg_addr(BaseAddr, REG_RBR_THR);
            xwdata = {24'd0, Divisor[7:0]};
          end
          3'd2: begin
            xaddr  = reg_addr(BaseAddr, REG_IER);
            xwdata = {24'd0, Divisor[15:8]};
          end
          3'd3: begin
            xaddr  = reg_addr(BaseAddr, REG_LCR);
            xwdata = {24'd0, LcrValue};
          end
          3'd4: begin
            xaddr  = reg_addr(BaseAddr, REG_FCR);
            xwdata = {24'd0, FcrValue};
          end
          default: begin
            xaddr  = reg_addr(BaseAddr, REG_IER);
            xwdata = '0;
          end
        endcase
        if (xdone && init_step_q == LAST_INIT_STEP) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gap_q == GAP_MAX && (!rx_full_q || tx_full_q)) state_d = ST_POLL;
      end
      ST_POLL: begin
        xreq = 1'b1;
        if (xdone) begin
          if (contested)    state_d = rr_rx_q ? ST_RD_RBR : ST_WR_THR;
          else if (rx_elig) state_d = ST_RD_RBR;
          else if (tx_elig) state_d = ST_WR_THR;
          else              state_d = ST_IDLE;
        end
      end
      ST_RD_RBR: begin
        xreq  = 1'b1;
        xaddr = reg_addr(BaseAddr, REG_RBR_THR);
        if (xdone) state_d = ST_IDLE;
      end
      ST_WR_THR: begin
        xreq   = 1'b1;
        xwrite = 1'b1;
        xaddr  = reg_addr(BaseAddr, REG_RBR_THR);
        xwdata = {24'd0, tx_byte_q};
        if (xdone) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_step_q <= '0;
      gap_q       <= '0;
      rr_rx_q     <= 1'b1;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= '0;
      rx_full_q   <= 1'b0;
      rx_byte_q   <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == ST_INIT && xdone) begin
        if (init_step_q == LAST_INIT_STEP) init_done_q <= 1'b1;
        else                               init_step_q <= init_step_q + 3'd1;
      end

      // Gap counter restarts on every entry to IDLE and saturates there.
      if (state_q != ST_IDLE)  gap_q <= '0;
      else if (gap_q != GAP_MAX) gap_q <= gap_q + 1'b1;

      if (xslverr) err_q <= 1'b1;

      if (state_q == ST_POLL && xdone && contested) rr_rx_q <= ~rr_rx_q;

      // Capture and THR completion are mutually exclusive: tx_ready_o is low
      // whenever a WR_THR can be in flight.
      if (tx_valid_i && tx_ready_o) begin
        tx_full_q <= 1'b1;
        tx_byte_q <= tx_data_i;
      end else if (state_q == ST_WR_THR && xdone) begin
        tx_full_q <= 1'b0;
      end

      // RBR is only read while rx is empty, so load and consume never meet.
      if (state_q == ST_RD_RBR && xdone && !xslverr) begin
        rx_full_q <= 1'b1;
        rx_byte_q <= xrdata;
      end else if (rx_full_q && rx_ready_i) begin
        rx_full_q <= 1'b0;
      end
    end
  end

  assign tx_ready_o  = init_done_q & ~tx_full_q;
  assign rx_valid_o  = rx_full_q;
  assign rx_data_o   = rx_byte_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;

  logic unused_dbg;
  assign unused_dbg = ^{xfer_state, REG_MCR};

endmodule
